// File: rtl/round_seq.sv
// Multi-cycle FPU rounding sequencer: sticky collection, increment, carry renormalisation, overflow substitution.
// Optional ROUND_SEQ_FLAGS_EN keeps the inexact/overflow flag registers; without it both flags read 0.
module round_seq #(
    parameter int N = 53,
    parameter int G = 53,
    parameter int E = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           sign_in,
    input  logic [E-1:0]   exp_in,
    input  logic [N+G-1:0] sig_in,
    input  logic [1:0]     rm_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sign_out,
    output logic [E-1:0]   exp_out,
    output logic [N-1:0]   sig_out,
    output logic           inexact,
    output logic           overflow
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid holds with its data until out_ready is seen.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STICKY = 3'd1;
    localparam logic [2:0] S_INC    = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic [E-1:0] EXP_INF = {E{1'b1}};
    localparam logic [E-1:0] EXP_MAX = {{(E-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] SIG_ONE = {1'b1, {(N-1){1'b0}}};

    logic [2:0]     state;
    logic           sign_r;
    logic [E-1:0]   exp_r;
    logic [N+G-1:0] sig_r;
    logic [1:0]     rm_r;
    logic           inc_r;
    logic [N-1:0]   sig_rnd;

    logic [N-1:0]   sig_hi;
    logic           bit_l, bit_r, bit_s;
    logic           inc_c;
    logic           sig_all_ones, exp_all_ones;
    logic [E-1:0]   res_exp;
    logic [N-1:0]   res_sig;

    assign in_ready = (state == S_IDLE);

    assign sig_hi = sig_r[N+G-1:G];
    assign bit_l  = sig_r[G];
    assign bit_r  = sig_r[G-1];
    assign bit_s  = |sig_r[G-2:0];

    // AND-tree reductions: significand carry-out and exponent overflow detection
    assign sig_all_ones = &sig_hi;
    assign exp_all_ones = &exp_r;

    always_comb begin
        inc_c = 1'b0;
        case (rm_r)
            RM_RNE:  inc_c = bit_r & (bit_s | bit_l);
            RM_RTZ:  inc_c = 1'b0;
            RM_RUP:  inc_c = ~sign_r & (bit_r | bit_s);
            RM_RDN:  inc_c = sign_r & (bit_r | bit_s);
            default: inc_c = 1'b0;
        endcase
    end

    // Overflow substitution: infinity when rounding away from zero, else largest finite
    always_comb begin
        res_exp = exp_r;
        res_sig = sig_rnd;
        if (exp_all_ones) begin
            res_exp = EXP_MAX;
            res_sig = {N{1'b1}};
            if ((rm_r == RM_RNE) ||
                (rm_r == RM_RUP && !sign_r) ||
                (rm_r == RM_RDN && sign_r)) begin
                res_exp = EXP_INF;
                res_sig = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            sig_r     <= '0;
            rm_r      <= RM_RNE;
            inc_r     <= 1'b0;
            sig_rnd   <= '0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            sig_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_r <= sign_in;
                        exp_r  <= exp_in;
                        sig_r  <= sig_in;
                        rm_r   <= rm_in;
                        state  <= S_STICKY;
                    end
                end
                S_STICKY: begin
                    inc_r <= inc_c;
                    state <= S_INC;
                end
                S_INC: begin
                    // An all-ones exponent is left alone so CHECK still sees the overflow
                    if (inc_r && sig_all_ones) begin
                        sig_rnd <= SIG_ONE;
                        if (!exp_all_ones) exp_r <= exp_r + 1'b1;
                    end else begin
                        sig_rnd <= sig_hi + {{(N-1){1'b0}}, inc_r};
                    end
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    sign_out <= sign_r;
                    exp_out  <= res_exp;
                    sig_out  <= res_sig;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ROUND_SEQ_FLAGS_EN
    logic rs_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_r     <= 1'b0;
            inexact  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == S_STICKY) rs_r <= bit_r | bit_s;
            if (state == S_CHECK) begin
                overflow <= exp_all_ones;
                inexact  <= exp_all_ones | rs_r;
            end
        end
    end
`else
    assign inexact  = 1'b0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_round_seq.sv
// Directed-vector bench for round_seq with N=8, G=4, E=4; expected results are hand-computed.
module tb_round_seq;

    localparam int N = 8;
    localparam int G = 4;
    localparam int E = 4;
`ifdef ROUND_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           sign_in;
    logic [E-1:0]   exp_in;
    logic [N+G-1:0] sig_in;
    logic [1:0]     rm_in;
    logic           out_valid;
    logic           out_ready;
    logic           sign_out;
    logic [E-1:0]   exp_out;
    logic [N-1:0]   sig_out;
    logic           inexact;
    logic           overflow;

    int errors = 0;
    int checks = 0;

    round_seq #(.N(N), .G(G), .E(E)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .sig_in(sig_in), .rm_in(rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .sig_out(sig_out),
        .inexact(inexact), .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: submit one operand, wait for the result, capture it, then hand it off
    task automatic do_op(input logic s, input logic [E-1:0] e, input logic [N+G-1:0] g,
                         input logic [1:0] rm, output int lat, output logic [14:0] res);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1; sign_in = s; exp_in = e; sig_in = g; rm_in = rm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
        end
        res = {sign_out, exp_out, sig_out, inexact, overflow};
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, sign_out, exp_out, sig_out, inexact, overflow} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h",
                     {in_ready, out_valid, sign_out, exp_out, sig_out, inexact, overflow}, {1'b1, 16'h0});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_rne;
        int lat; logic [14:0] res, exp_res;
        do_op(1'b0, 4'd5, 12'b1000_0001_1000, 2'b00, lat, res);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL rne_up_latency: got %0d edges required 4", lat); end
        exp_res = {1'b0, 4'd5, 8'b1000_0010, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rne_up: got %h required %h", res, exp_res); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rne_handoff: out_valid=%0b required 0", out_valid); end

        do_op(1'b0, 4'd5, 12'b1000_0000_1000, 2'b00, lat, res);
        exp_res = {1'b0, 4'd5, 8'b1000_0000, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rne_tie_even: got %h required %h", res, exp_res); end

        do_op(1'b1, 4'd9, 12'b1010_0000_0000, 2'b00, lat, res);
        exp_res = {1'b1, 4'd9, 8'b1010_0000, 1'b0, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rne_exact: got %h required %h", res, exp_res); end

        do_op(1'b0, 4'd2, 12'b1000_0011_1001, 2'b00, lat, res);
        exp_res = {1'b0, 4'd2, 8'b1000_0100, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rne_above_half: got %h required %h", res, exp_res); end
    endtask

    task automatic test_directed_modes;
        int lat; logic [14:0] res, exp_res;
        do_op(1'b0, 4'd3, 12'b1000_0000_0001, 2'b10, lat, res);
        exp_res = {1'b0, 4'd3, 8'b1000_0001, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rup_pos_sticky: got %h required %h", res, exp_res); end

        do_op(1'b0, 4'd3, 12'b1000_0000_0001, 2'b11, lat, res);
        exp_res = {1'b0, 4'd3, 8'b1000_0000, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rdn_pos_sticky: got %h required %h", res, exp_res); end

        do_op(1'b1, 4'd7, 12'b1100_0000_0100, 2'b11, lat, res);
        exp_res = {1'b1, 4'd7, 8'b1100_0001, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rdn_neg: got %h required %h", res, exp_res); end

        do_op(1'b0, 4'd7, 12'b1100_0001_1111, 2'b01, lat, res);
        exp_res = {1'b0, 4'd7, 8'b1100_0001, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL rtz_trunc: got %h required %h", res, exp_res); end
    endtask

    task automatic test_carry;
        int lat; logic [14:0] res, exp_res;
        do_op(1'b0, 4'd5, 12'b1111_1111_1100, 2'b00, lat, res);
        exp_res = {1'b0, 4'd6, 8'b1000_0000, FLAGS_EN, 1'b0};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL carry_renorm: got %h required %h", res, exp_res); end
    endtask

    task automatic test_overflow;
        int lat; logic [14:0] res, exp_res;
        do_op(1'b0, 4'd14, 12'b1111_1111_1000, 2'b00, lat, res);
        exp_res = {1'b0, 4'd15, 8'h00, FLAGS_EN, FLAGS_EN};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL ovf_rne_inf: got %h required %h", res, exp_res); end

        do_op(1'b0, 4'd15, 12'b1111_1111_1000, 2'b01, lat, res);
        exp_res = {1'b0, 4'd14, 8'hFF, FLAGS_EN, FLAGS_EN};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL ovf_rtz_max: got %h required %h", res, exp_res); end

        do_op(1'b1, 4'd15, 12'b1111_1111_1000, 2'b11, lat, res);
        exp_res = {1'b1, 4'd15, 8'h00, FLAGS_EN, FLAGS_EN};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL ovf_rdn_neginf: got %h required %h", res, exp_res); end

        do_op(1'b1, 4'd15, 12'b1010_0000_0000, 2'b10, lat, res);
        exp_res = {1'b1, 4'd14, 8'hFF, FLAGS_EN, FLAGS_EN};
        checks++;
        if (res !== exp_res) begin errors++; $display("FAIL ovf_rup_neg_max: got %h required %h", res, exp_res); end
    endtask

    task automatic test_backpressure;
        int w; logic [14:0] res, exp_res;
        @(negedge clk);
        in_valid = 1'b1; sign_in = 1'b1; exp_in = 4'd5; sig_in = 12'b1000_0001_1000; rm_in = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        exp_res = {1'b1, 4'd5, 8'b1000_0010, FLAGS_EN, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            res = {sign_out, exp_out, sig_out, inexact, overflow};
            checks++;
            if ({out_valid, in_ready, res} !== {1'b1, 1'b0, exp_res}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got %b_%b_%h required 1_0_%h", i, out_valid, in_ready, res, exp_res);
            end
            in_valid = i[0]; sign_in = 1'b0; exp_in = 4'd14; sig_in = 12'hFFF; rm_in = 2'b10;
        end
        @(negedge clk);
        in_valid = 1'b1; sign_in = 1'b0; exp_in = 4'd7; sig_in = 12'b1010_0000_0000; rm_in = 2'b01;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_handoff: valid_ready=%b required 01", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: in_ready=%0b required 0", in_ready); end
        w = 0;
        while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
        res = {sign_out, exp_out, sig_out, inexact, overflow};
        exp_res = {1'b0, 4'd7, 8'b1010_0000, 1'b0, 1'b0};
        checks++;
        if ({w, res} !== {32'd4, exp_res}) begin
            errors++; $display("FAIL bp_second_result: got lat=%0d %h required lat=4 %h", w, res, exp_res);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat; logic [14:0] res, exp_res;
        @(negedge clk);
        in_valid = 1'b1; sign_in = 1'b1; exp_in = 4'd3; sig_in = 12'b1100_1100_1100; rm_in = 2'b00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sign_out, exp_out, sig_out, inexact, overflow} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid_values: got %h required %h",
                     {in_ready, out_valid, sign_out, exp_out, sig_out, inexact, overflow}, {1'b1, 16'h0});
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++; $display("FAIL reset_mid_idle_%0d: valid_ready=%b required 01", i, {out_valid, in_ready});
            end
        end
        do_op(1'b1, 4'd3, 12'b1100_1100_1100, 2'b00, lat, res);
        exp_res = {1'b1, 4'd3, 8'b1100_1101, FLAGS_EN, 1'b0};
        checks++;
        if ({lat, res} !== {32'd4, exp_res}) begin
            errors++; $display("FAIL reset_mid_new_op: got lat=%0d %h required lat=4 %h", lat, res, exp_res);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; sign_in = 1'b0; exp_in = '0; sig_in = '0; rm_in = 2'b00;
        rst_n = 1'b0;
        test_reset();
        test_rne();
        test_directed_modes();
        test_carry();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
